// File: rtl/ryuki_datatypes.sv
// Shared datatypes for the ryuki trace path: the trace record produced by
// the dragreder trace unit and the trace_buffer state encoding.
package ryuki_datatypes;

  // One trace record as emitted by dragreder.
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  opcode;
    logic [7:0]  tag;
  } trace_output;

  // trace_buffer acceptance state: NORMAL accepts pushes, OVERFLOW drops
  // them until occupancy drains to the resume level.
  typedef enum logic {
    TB_NORMAL,
    TB_OVERFLOW
  } trace_buf_state_e;

endpackage

// File: rtl/trace_buffer_mem.sv
// Record storage for trace_buffer: DEPTH entries, one synchronous write
// port and one asynchronous read port (first-word fall-through head).
module trace_buffer_mem
  import ryuki_datatypes::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  trace_output   wdata,
  input  logic [AW-1:0] raddr,
  output trace_output   rdata
);

  trace_output mem [DEPTH];

  // Write the accepted record into its slot.
  // NOTE: storage is deliberately not reset; occupancy/valid gate its use,
  // so clearing it would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: elastic FIFO between the dragreder trace unit and the trace
// sink. Drops whole records on overflow and stays in a drop state until the
// occupancy falls to RESUME_LEVEL, so trace gaps are visible on overflow_o.
// Optional statistics (dropped_o, high_water_o) are built only when the
// macro TRACE_BUFFER_STATS_EN is defined; otherwise those ports read 0.
module trace_buffer
  import ryuki_datatypes::*;
#(
  parameter int DEPTH        = 16,
  parameter int RESUME_LEVEL = DEPTH / 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_data_ready,
  input  trace_output              trace_data_i,
  output logic                     trace_valid_o,
  output trace_output              trace_data_o,
  input  logic                     trace_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              dropped_o,
  output logic [$clog2(DEPTH):0]   high_water_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] RESUME_C = CW'(RESUME_LEVEL);

  trace_buf_state_e state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  trace_output      head;
  logic             pop;
  logic             acc;
  logic             drop;

  assign trace_valid_o = (count != '0);
  assign pop           = trace_valid_o & trace_ready_i;
  // A full buffer still accepts when the head leaves in the same cycle.
  assign acc  = trace_data_ready & (state == TB_NORMAL) & ((count < DEPTH_C) | pop);
  assign drop = trace_data_ready & ~acc;

  // Next occupancy from the accept/pop pair.
  // NOTE: combinational blocks assign every output first, so no latch forms.
  always_comb begin
    count_next = count;
    case ({acc, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  trace_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (acc),
    .waddr (wr_ptr),
    .wdata (trace_data_i),
    .raddr (rd_ptr),
    .rdata (head)
  );

  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign trace_data_o = trace_valid_o ? head : '0;

  // Pointers, occupancy and the NORMAL/OVERFLOW hysteresis state.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= TB_NORMAL;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      case (state)
        TB_NORMAL:   if (drop) state <= TB_OVERFLOW;
        TB_OVERFLOW: if (count <= RESUME_C) state <= TB_NORMAL;
        default:     state <= TB_NORMAL;
      endcase
    end
  end

  assign count_o    = count;
  assign overflow_o = (state == TB_OVERFLOW);

`ifdef TRACE_BUFFER_STATS_EN
  logic [15:0]   dropped;
  logic [CW-1:0] high_water;

  // Saturating drop counter and peak occupancy, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dropped    <= '0;
      high_water <= '0;
    end else begin
      if (drop && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
      if (count_next > high_water) high_water <= count_next;
    end
  end

  assign dropped_o    = dropped;
  assign high_water_o = high_water;
`else
  assign dropped_o    = '0;
  assign high_water_o = '0;
`endif

endmodule

// File: tb/tb_trace_buffer.sv
// Directed self-checking bench for trace_buffer (DEPTH=16, RESUME_LEVEL=8).
// Statistics expectations follow TRACE_BUFFER_STATS_EN as compiled.
module tb_trace_buffer;
  import ryuki_datatypes::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_data_ready;
  trace_output trace_data_i;
  logic        trace_valid_o;
  trace_output trace_data_o;
  logic        trace_ready_i;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [15:0] dropped_o;
  logic [4:0]  high_water_o;

  int checks = 0;
  int passed = 0;

  trace_buffer #(.DEPTH(DEPTH), .RESUME_LEVEL(DEPTH / 2)) dut (
    .clk              (clk),
    .rst              (rst),
    .trace_data_ready (trace_data_ready),
    .trace_data_i     (trace_data_i),
    .trace_valid_o    (trace_valid_o),
    .trace_data_o     (trace_data_o),
    .trace_ready_i    (trace_ready_i),
    .count_o          (count_o),
    .overflow_o       (overflow_o),
    .dropped_o        (dropped_o),
    .high_water_o     (high_water_o)
  );

  always #5 clk = ~clk;

  function automatic trace_output rec(input int i);
    trace_output r;
    r.pc     = 32'h1000 + 32'(i) * 32'd4;
    r.opcode = 8'(i);
    r.tag    = ~8'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
  endtask

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag, input int drops, input int hw);
`ifdef TRACE_BUFFER_STATS_EN
    check({tag, "_dropped"}, 64'(dropped_o), 64'(drops));
    check({tag, "_high_water"}, 64'(high_water_o), 64'(hw));
`else
    check({tag, "_dropped"}, 64'(dropped_o), 64'(0));
    check({tag, "_high_water"}, 64'(high_water_o), 64'(0));
    if (drops < 0 || hw < 0) $display("negative expectation %0d %0d", drops, hw);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1: reset with push strobe held high.
    rst = 1'b1; trace_data_ready = 1'b1; trace_data_i = rec(999); trace_ready_i = 1'b0;
    step(); step();
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_valid", 64'(trace_valid_o), 64'(0));
    check("rst_overflow", 64'(overflow_o), 64'(0));
    check("rst_data", 64'(trace_data_o), 64'(0));
    check_stats("rst", 0, 0);
    rst = 1'b0; trace_data_ready = 1'b0;
    step();

    // Test 2: single record, one-cycle latency.
    trace_data_ready = 1'b1; trace_data_i = rec(1); trace_ready_i = 1'b1;
    step();
    trace_data_ready = 1'b0;
    check("single_valid", 64'(trace_valid_o), 64'(1));
    check("single_data", 64'(trace_data_o), 64'(rec(1)));
    check("single_count1", 64'(count_o), 64'(1));
    step();
    check("single_count0", 64'(count_o), 64'(0));
    check("single_valid0", 64'(trace_valid_o), 64'(0));

    // Test 3: backpressure, 20 pushes into 16 entries.
    trace_ready_i = 1'b0; trace_data_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      trace_data_i = rec(i);
      step();
    end
    check("bp_count", 64'(count_o), 64'(16));
    check("bp_overflow", 64'(overflow_o), 64'(1));
    check("bp_valid", 64'(trace_valid_o), 64'(1));
    check_stats("bp", 4, 16);

    // Test 4: hysteresis; pushes keep being dropped while draining to 8.
    trace_ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      trace_data_i = rec(100 + k);
      check($sformatf("hyst_data%0d", k), 64'(trace_data_o), 64'(rec(k)));
      step();
    end
    check("hyst_count8", 64'(count_o), 64'(8));
    check("hyst_still_ovf", 64'(overflow_o), 64'(1));
    // Exit cycle: push still dropped, state returns to NORMAL.
    trace_data_i = rec(150);
    check("hyst_data8", 64'(trace_data_o), 64'(rec(8)));
    step();
    check("hyst_exit_ovf", 64'(overflow_o), 64'(0));
    check("hyst_exit_count", 64'(count_o), 64'(7));
    check_stats("hyst_exit", 13, 16);
    // Next push accepted alongside a pop.
    trace_data_i = rec(200);
    check("hyst_data9", 64'(trace_data_o), 64'(rec(9)));
    step();
    trace_data_ready = 1'b0;
    check("hyst_accept_count", 64'(count_o), 64'(7));
    for (int k = 10; k < 16; k++) begin
      check($sformatf("drain_data%0d", k), 64'(trace_data_o), 64'(rec(k)));
      step();
    end
    check("drain_new_rec", 64'(trace_data_o), 64'(rec(200)));
    step();
    check("drain_count", 64'(count_o), 64'(0));
    check("drain_valid", 64'(trace_valid_o), 64'(0));

    // Test 5: full buffer, push and pop in the same cycle.
    trace_ready_i = 1'b0; trace_data_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      trace_data_i = rec(300 + i);
      step();
    end
    check("full_count", 64'(count_o), 64'(16));
    check("full_overflow", 64'(overflow_o), 64'(0));
    trace_data_i = rec(400); trace_ready_i = 1'b1;
    check("full_head", 64'(trace_data_o), 64'(rec(300)));
    step();
    trace_data_ready = 1'b0;
    check("pp_count", 64'(count_o), 64'(16));
    check("pp_overflow", 64'(overflow_o), 64'(0));
    check_stats("pp", 13, 16);
    for (int i = 1; i < 16; i++) begin
      check($sformatf("pp_data%0d", i), 64'(trace_data_o), 64'(rec(300 + i)));
      step();
    end
    check("pp_last", 64'(trace_data_o), 64'(rec(400)));
    step();
    check("pp_empty", 64'(count_o), 64'(0));

    // Reset mid-stream discards contents and clears stats.
    trace_ready_i = 1'b0; trace_data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      trace_data_i = rec(500 + i);
      step();
    end
    check("mid_count", 64'(count_o), 64'(3));
    rst = 1'b1;
    step();
    rst = 1'b0; trace_data_ready = 1'b0;
    check("mid_rst_count", 64'(count_o), 64'(0));
    check("mid_rst_valid", 64'(trace_valid_o), 64'(0));
    check_stats("mid_rst", 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
